// File: rtl/tdm_demux_2ch_pkg.sv
// Shared definitions for the 2-channel bit-interleaved TDM link.
// Both the demux (receive) side and the future mux (transmit) side use them.
package tdm_demux_2ch_pkg;

  typedef enum logic {
    TDM_HUNT   = 1'b0,
    TDM_LOCKED = 1'b1
  } tdm_state_t;

  function automatic int frame_len(input int width);
    return 2 * width;
  endfunction

  function automatic int ctr_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/tdm_demux_2ch_word_collector.sv
// LSB-first word assembler for one TDM channel: shifts in steered bits and
// publishes the finished word with a one-cycle valid pulse.
module tdm_demux_2ch_word_collector
  import tdm_demux_2ch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             load_out,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] sr;

  // New bits enter at the MSB so the first bit of the word ends up at bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clear) begin
        sr <= shift_en ? {bit_in, {(WIDTH-1){1'b0}}} : '0;
      end else if (shift_en) begin
        sr <= {bit_in, sr[WIDTH-1:1]};
        if (load_out) begin
          data  <= {bit_in, sr[WIDTH-1:1]};
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tdm_demux_2ch.sv
// Receive side of the 2-channel bit-interleaved TDM link: frame alignment
// from fsync, even/odd steering into two word collectors, sync error reporting.
module tdm_demux_2ch
  import tdm_demux_2ch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  output logic             locked,
  output logic             frame_err
);

  localparam int FLEN = frame_len(WIDTH);
  localparam int KW   = ctr_width(WIDTH);
  localparam logic [KW-1:0] K_LAST_A = KW'(FLEN - 2);
  localparam logic [KW-1:0] K_LAST   = KW'(FLEN - 1);

  tdm_state_t state;
  logic [KW-1:0] k;
  logic a_shift, a_clear, a_load;
  logic b_shift, b_clear, b_load;

  // Any fsync restarts both words with the current bit as channel-A bit 0;
  // otherwise locked bits are steered by frame-bit parity.
  always_comb begin
    a_shift = 1'b0;
    a_clear = 1'b0;
    a_load  = 1'b0;
    b_shift = 1'b0;
    b_clear = 1'b0;
    b_load  = 1'b0;
    if (din_valid) begin
      if (fsync) begin
        a_clear = 1'b1;
        a_shift = 1'b1;
        b_clear = 1'b1;
      end else if (state == TDM_LOCKED && k != '0) begin
        if (k[0]) begin
          b_shift = 1'b1;
          b_load  = (k == K_LAST);
        end else begin
          a_shift = 1'b1;
          a_load  = (k == K_LAST_A);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= TDM_HUNT;
      k         <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (din_valid) begin
        if (fsync) begin
          frame_err <= (state == TDM_LOCKED) && (k != '0);
          state     <= TDM_LOCKED;
          locked    <= 1'b1;
          k         <= KW'(1);
        end else if (state == TDM_LOCKED) begin
          if (k == '0) begin
            frame_err <= 1'b1;
            state     <= TDM_HUNT;
            locked    <= 1'b0;
          end else begin
            k <= (k == K_LAST) ? '0 : k + KW'(1);
          end
        end
      end
    end
  end

  tdm_demux_2ch_word_collector #(.WIDTH(WIDTH)) u_col_a (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (din),
    .shift_en (a_shift),
    .clear    (a_clear),
    .load_out (a_load),
    .data     (a_data),
    .valid    (a_valid)
  );

  tdm_demux_2ch_word_collector #(.WIDTH(WIDTH)) u_col_b (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (din),
    .shift_en (b_shift),
    .clear    (b_clear),
    .load_out (b_load),
    .data     (b_data),
    .valid    (b_valid)
  );

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Self-checking bench for tdm_demux_2ch: table-driven clean frames plus
// hand-written sync-violation and reset sequences, scoreboarded valids.
module tb_tdm_demux_2ch;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             fsync = 1'b0;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             locked;
  logic             frame_err;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit             is_b;
    logic [WIDTH-1:0] data;
    int             cyc;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int             gap;
    int             noise;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  exp_t sb_q[$];
  int   err_q[$];
  vec_t vecs[5];

  tdm_demux_2ch #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .fsync     (fsync),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .locked    (locked),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic fs);
    @(posedge clk);
    #1;
    din       = d;
    din_valid = 1'b1;
    fsync     = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      fsync     = 1'b0;
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    din_valid = 1'b0;
    fsync     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sends the first nbits of an interleaved frame and registers what must come out.
  task automatic sendBits(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int nbits,
                          input int gap, input bit fs_first, input bit err_first,
                          input bit expect_words, input bit check_rise);
    exp_t e;
    logic bitv;
    for (int k = 0; k < nbits; k++) begin
      bitv = (k % 2 == 0) ? a[k/2] : b[k/2];
      applyStimulus(bitv, fs_first && (k == 0));
      if (k == 0 && err_first) err_q.push_back(cyc + 1);
      if (expect_words && k == 2*WIDTH-2) begin
        e.is_b = 1'b0; e.data = a; e.cyc = cyc + 1;
        sb_q.push_back(e);
      end
      if (expect_words && k == 2*WIDTH-1) begin
        e.is_b = 1'b1; e.data = b; e.cyc = cyc + 1;
        sb_q.push_back(e);
      end
      if (check_rise && k == 0) begin
        @(negedge clk);
        checkOutput("locked_before_sync", 32'(locked), 32'd0);
      end
      if (check_rise && k == 1) begin
        @(negedge clk);
        checkOutput("locked_rise", 32'(locked), 32'd1);
      end
      if (gap > 0 && k < nbits-1) idle(gap);
    end
  endtask

  // Valid and frame_err pulses are matched against what the driver expected.
  always @(negedge clk) begin
    exp_t e;
    if (a_valid === 1'b1) begin
      if (sb_q.size() == 0) checkOutput("unexpected_a_valid", 32'(a_data), 32'hFFFF_FFFF);
      else begin
        e = sb_q.pop_front();
        checkOutput("a_valid_channel", 32'(0), 32'(e.is_b));
        checkOutput("a_data", 32'(a_data), 32'(e.data));
        checkOutput("a_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (b_valid === 1'b1) begin
      if (sb_q.size() == 0) checkOutput("unexpected_b_valid", 32'(b_data), 32'hFFFF_FFFF);
      else begin
        e = sb_q.pop_front();
        checkOutput("b_valid_channel", 32'(1), 32'(e.is_b));
        checkOutput("b_data", 32'(b_data), 32'(e.data));
        checkOutput("b_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (frame_err === 1'b1) begin
      if (err_q.size() == 0) checkOutput("unexpected_frame_err", 32'(cyc), 32'hFFFF_FFFF);
      else checkOutput("frame_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d, expected under 5000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 0, 0, 8'hA5, 8'h3C};
    vecs[1] = '{8'hA5, 8'h3C, 0, 5, 8'hA5, 8'h3C};
    vecs[2] = '{8'hA5, 8'h3C, 3, 0, 8'hA5, 8'h3C};
    vecs[3] = '{8'hFF, 8'h00, 1, 2, 8'hFF, 8'h00};
    vecs[4] = '{8'h01, 8'h80, 0, 7, 8'h01, 8'h80};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_a_data", 32'(a_data), 32'd0);
    checkOutput("reset_b_data", 32'(b_data), 32'd0);
    checkOutput("reset_a_valid", 32'(a_valid), 32'd0);
    checkOutput("reset_b_valid", 32'(b_valid), 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = vecs[i];
      doReset();
      for (int j = 0; j < v.noise; j++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      sendBits(v.a, v.b, 2*WIDTH, v.gap, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(2);
      @(negedge clk);
      checkOutput("vec_a_hold", 32'(a_data), 32'(v.exp_a));
      checkOutput("vec_b_hold", 32'(b_data), 32'(v.exp_b));
      checkOutput("vec_locked", 32'(locked), 32'd1);
    end

    doReset();
    sendBits(8'hA5, 8'h3C, 2*WIDTH, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    sendBits(8'h55, 8'hAA, 6, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    sendBits(8'h12, 8'h34, 2*WIDTH, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("early_locked", 32'(locked), 32'd1);
    checkOutput("early_a_data", 32'(a_data), 32'h12);
    checkOutput("early_b_data", 32'(b_data), 32'h34);

    sendBits(8'h5A, 8'hC3, 2*WIDTH-1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    sendBits(8'h0F, 8'hF0, 2*WIDTH, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    checkOutput("late_fsync_a_data", 32'(a_data), 32'h0F);
    checkOutput("late_fsync_b_data", 32'(b_data), 32'hF0);

    sendBits(8'h77, 8'h88, 2*WIDTH, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    checkOutput("missing_sync_locked", 32'(locked), 32'd0);
    checkOutput("missing_sync_b_hold", 32'(b_data), 32'hF0);
    sendBits(8'h9C, 8'h63, 2*WIDTH, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2);

    sendBits(8'hA5, 8'h3C, 9, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    din       = 1'b1;
    din_valid = 1'b1;
    fsync     = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    checkOutput("midreset_a_data", 32'(a_data), 32'd0);
    checkOutput("midreset_b_data", 32'(b_data), 32'd0);
    checkOutput("midreset_a_valid", 32'(a_valid), 32'd0);
    checkOutput("midreset_b_valid", 32'(b_valid), 32'd0);
    checkOutput("midreset_locked", 32'(locked), 32'd0);
    checkOutput("midreset_frame_err", 32'(frame_err), 32'd0);
    sendBits(8'h11, 8'h22, 2*WIDTH, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    checkOutput("nosync_locked", 32'(locked), 32'd0);
    sendBits(8'h3C, 8'hA5, 2*WIDTH, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("relock_a_data", 32'(a_data), 32'h3C);
    checkOutput("relock_b_data", 32'(b_data), 32'hA5);

    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    checkOutput("frame_err_drained", 32'(err_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
